// File: rtl/vram_shadow_if.sv
// CPU snoop bus and video fetch port of the VRAM shadow.
// The CPU-side signals and the video fetch request are driven by the master.
// The slave, which is the shadow RAM, returns the fetched byte.
interface vram_shadow_if;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        nMREQ;
  logic        nWR;
  logic        nRFSH;
  logic        m128;
  logic [2:0]  page_ram;
  logic        shadow_ena;
  logic        vram_req;
  logic [14:0] vram_addr;
  logic [7:0]  vram_dout;

  modport master (
    output addr, din, nMREQ, nWR, nRFSH, m128, page_ram, shadow_ena,
    output vram_req, vram_addr,
    input  vram_dout
  );

  modport slave (
    input  addr, din, nMREQ, nWR, nRFSH, m128, page_ram, shadow_ena,
    input  vram_req, vram_addr,
    output vram_dout
  );
endinterface

// File: rtl/vram_shadow.sv
// 32 KB shadow screen RAM for the video controller.
// Video reads have priority. The RAM is then zero-filled after reset.
// Snooped CPU writes to pages 5 and 7 are queued and committed in idle slots.
//
// Video fetch handshake: vram_req is a level request. Each cycle it is high,
// the RAM reads vram_addr. The byte appears on vram_dout after the following
// edge. vram_dout holds its value while no read is in flight.
module vram_shadow #(
  parameter int FIFO_DEPTH     = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk_sys,
  input  logic           reset,
  vram_shadow_if.slave   bus,
  output logic           clear_busy,
  output logic           wr_overflow,
  output logic           o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state, w_next_state;
  logic [14:0] r_clr_cnt;
  logic        r_wr_old;
  logic [22:0] r_fifo [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        r_overflow;
  logic [7:0]  r_ram [32768];
  logic [7:0]  r_ram_q;
  logic        r_rd_vld;
  logic [7:0]  r_dout;

  logic        w_wr_act, w_cap, w_hit_b0, w_hit_b1, w_push, w_pop;
  logic        w_empty, w_full, w_accept;
  logic [22:0] w_head;
  logic [14:0] w_ram_addr;
  logic [7:0]  w_ram_wdata;
  logic        w_ram_we, w_ram_re, w_clr_inc;

  // CPU write strobe qualification and address decode into a bank/offset.
  assign w_wr_act = ~bus.nMREQ & ~bus.nWR & bus.nRFSH & bus.shadow_ena;
  assign w_cap    = ~r_wr_old & w_wr_act;
  assign w_hit_b0 = (bus.addr[15:14] == 2'b01) |
                    (bus.m128 & (bus.addr[15:14] == 2'b11) & (bus.page_ram == 3'd5));
  assign w_hit_b1 = bus.m128 & (bus.addr[15:14] == 2'b11) & (bus.page_ram == 3'd7);
  assign w_push   = w_cap & (w_hit_b0 | w_hit_b1) & (r_state == S_RUN);

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_head   = r_fifo[r_rptr[AW-1:0]];

  assign clear_busy  = (r_state == S_CLEAR);
  assign wr_overflow = r_overflow;
  assign bus.vram_dout = r_dout;
  assign o_dbg_state = r_state;

  // RAM port arbitration: video read, then clear write, then FIFO commit.
  always_comb begin
    w_next_state = r_state;
    w_ram_addr   = bus.vram_addr;
    w_ram_wdata  = 8'h00;
    w_ram_we     = 1'b0;
    w_ram_re     = 1'b0;
    w_pop        = 1'b0;
    w_clr_inc    = 1'b0;
    if (bus.vram_req) begin
      w_ram_re = 1'b1;
    end else if (r_state == S_CLEAR) begin
      w_ram_we   = 1'b1;
      w_ram_addr = r_clr_cnt;
      w_clr_inc  = 1'b1;
      if (r_clr_cnt == 15'h7FFF) w_next_state = S_RUN;
    end else if (!w_empty) begin
      w_ram_we    = 1'b1;
      w_ram_addr  = w_head[22:8];
      w_ram_wdata = w_head[7:0];
      w_pop       = 1'b1;
    end
  end

  // State, clear counter, strobe edge detect, FIFO pointers and overflow flag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      r_clr_cnt  <= 15'd0;
      r_wr_old   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_wr_old <= w_wr_act;
      if (w_clr_inc) r_clr_cnt <= r_clr_cnt + 15'd1;
      if (w_accept)  r_wptr    <= r_wptr + 1'b1;
      if (w_pop)     r_rptr    <= r_rptr + 1'b1;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; stale contents are harmless because the pointers reset.
  always_ff @(posedge clk_sys) begin
    if (w_accept) r_fifo[r_wptr[AW-1:0]] <= {w_hit_b1, bus.addr[13:0], bus.din};
  end

  // Single-port screen RAM with synchronous read.
  always_ff @(posedge clk_sys) begin
    if (w_ram_we) r_ram[w_ram_addr] <= w_ram_wdata;
    if (w_ram_re) r_ram_q <= r_ram[w_ram_addr];
  end

  // Output register: loads the RAM byte one edge after each video read.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_rd_vld <= 1'b0;
      r_dout   <= 8'h00;
    end else begin
      r_rd_vld <= w_ram_re;
      if (r_rd_vld) r_dout <= r_ram_q;
    end
  end

endmodule

// File: doc/vram_shadow.md
# vram_shadow

Responder side of the video controller's VRAM fetch port: owns a 32 KB single-port screen RAM, serves the controller's `vram_req`/`vram_addr` reads with a registered `vram_dout`, and keeps the RAM coherent by snooping CPU memory writes into RAM pages 5 and 7. CPU writes are queued in a small FIFO and committed only in cycles where the video controller is not reading. It sits between the Z80 bus and the video controller, beside the main memory controller.

## Interface
- `FIFO_DEPTH`, 4: CPU write queue entries; power of two, ≥2.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill the RAM after reset; 0 = enter RUN directly.

- `clk_sys`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr`  in  16  CPU address bus.
- `din`  in  8  CPU data-out bus.
- `nMREQ`, `nWR`, `nRFSH`  in  1 each  CPU strobes, active-low.
- `m128`  in  1  128K paging active.
- `page_ram`  in  3  RAM page mapped at 0xC000.
- `shadow_ena`  in  1  1 = capture CPU writes.
- `vram_req`  in  1  video fetch request, level.
- `vram_addr`  in  15  fetch address; bit 14 = bank (0 = page 5, 1 = page 7).
- `vram_dout`  out  8  fetched byte.
- `clear_busy`  out  1  zero-fill in progress.
- `wr_overflow`  out  1  sticky: a captured write was dropped.

## Operation
- Storage: 32768 x 8 single-port RAM, synchronous read, one access per `clk_sys`.
- Port priority per cycle: (1) video read when `vram_req`=1; (2) CLEAR write; (3) FIFO head commit. Exactly one access per cycle.
- Video read: while `vram_req`=1, read `vram_addr` every cycle; `vram_dout` registered from RAM output. While `vram_req`=0, `vram_dout` holds its last value.
- Write snoop: `wr_act = ~nMREQ & ~nWR & nRFSH & shadow_ena`; register `wr_old`. Capture on `~wr_old & wr_act` only, using `addr`/`din` in that cycle. One capture per CPU write cycle.
- Decode of a capture:
  - `addr[15:14]`=01 -> bank 0, offset `addr[13:0]`.
  - `m128` & `addr[15:14]`=11 & `page_ram`=5 -> bank 0. `page_ram`=7 -> bank 1.
  - Anything else is ignored and not queued.
  - 0x4000 with page 5 at 0xC000 both hit bank 0; both are queued, in arrival order.
- FIFO: 23-bit entries {bank, offset, data}. Push on decoded capture. Pop when RAM slot 3 is granted.
  - Simultaneous push and pop allowed, including when full; the push is accepted.
  - Push while full without pop: entry dropped, `wr_overflow` set until reset.
  - Commit order is strictly FIFO.
  - No read forwarding: a video read of an address with a pending write returns the old RAM byte.
- State machine:
  - CLEAR (entered from reset when `CLEAR_ON_RESET`=1): 15-bit counter from 0. Each cycle with `vram_req`=0, write 0 at counter and increment. After writing 0x7FFF, go to RUN. Captures are ignored (not queued, no overflow). Video reads are still served.
  - RUN: normal operation. RUN is never left except by reset.
- Reset mid-operation: FIFO flushed, pending writes lost, state restarts per `CLEAR_ON_RESET`. RAM contents are not reset except by CLEAR.

## Timing
- Reset values: `vram_dout`=0, `wr_overflow`=0, FIFO empty, `wr_old`=0, clear counter 0. `clear_busy`=1 if `CLEAR_ON_RESET` else 0.
- Read latency: `vram_addr` sampled at edge N with `vram_req`=1 -> data on `vram_dout` after edge N+1.
  - The video controller samples one `ce_7mn` after raising `vram_req`, at least 2 `clk_sys` later, so the data is always settled.
- Write path: capture at edge C, FIFO entry visible at C+1. Earliest RAM commit at edge C+1, provided `vram_req`=0 in that cycle.
- Write starvation bound: the controller drops `vram_req` in alternate `ce_7mn` periods, so the FIFO drains at least one entry per 2 `ce_7mn` periods. Depth 4 covers back-to-back Z80 writes.
- `clear_busy` falls the cycle after the 0x7FFF write.
- CLEAR duration: 32768 + (number of `vram_req`=1 cycles during clear) cycles.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, `vram_req`=0 -> `clear_busy` high for exactly 32768 cycles. A read of 0x1234 afterwards returns 0x00.
- RUN, CPU write 0x4000<=0xA5 with `vram_req`=0 -> committed at C+1. `vram_req`=1, `vram_addr`=0x0000 -> `vram_dout`=0xA5 one cycle later.
- `m128`=1, `page_ram`=7, write 0xC010<=0x3C -> bank 1. Read `vram_addr`=0x4010 returns 0x3C, and 0x0010 is unchanged.
- `page_ram`=2, write 0xC010 -> nothing queued. Write 0x8000 -> ignored. Write with `nRFSH`=0 -> ignored.
- Hold `vram_req`=1, issue 5 decoded writes with `FIFO_DEPTH`=4 -> `wr_overflow`=1, 5th write lost. Release `vram_req` -> first 4 commit in order.
- Reset asserted while 3 entries pending -> outputs return to reset values immediately and no pending entry is committed.
